text_number_writer: RTL and testbench

- Text-buffer client: converts a 16-bit unsigned value to 5 ASCII decimal characters and writes them into the shared 1024x8 text buffer.
- Sits directly upstream of the text block. Occupies one Request/Grant slot of its mutex and drives that slot's Address/Data/Write_Enable.
- Typical users: frequency, volume and status readouts in the broadcast text stream.

---
 rtl/text_pkg.sv | 19 +
 rtl/bin_to_bcd.sv | 46 ++++
 rtl/text_number_writer.sv | 120 ++++++++++++
 tb/tb_text_number_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants and state encoding for text-buffer clients.
package text_pkg;
    localparam int TEXT_ADDR_W = 10;
    localparam int TEXT_DATA_W = 8;
    localparam int NUM_DIGITS  = 5;
    localparam int BIN_W       = 16;
    localparam int BCD_W       = 4 * NUM_DIGITS;

    localparam logic [TEXT_DATA_W-1:0] ASCII_ZERO  = 8'h30;
    localparam logic [TEXT_DATA_W-1:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_REQUEST,
        S_WRITE,
        S_RELEASE
    } state_e;
endpackage

// File: rtl/bin_to_bcd.sv
// Serial double-dabble: 16 adjust+shift steps after a start pulse.
module bin_to_bcd
    import text_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj;
    logic [3:0]       cnt_q;
    logic             run_q;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            {bcd_q, bin_q} <= {adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_q          <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) run_q <= 1'b0;
        end
    end

    // High on the edge that performs the final shift.
    assign done_o = run_q && (cnt_q == 4'd15);
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/text_number_writer.sv
// Converts a 16-bit value to 5 ASCII digits and writes them to the text buffer via its mutex slot.
module text_number_writer
    import text_pkg::*;
#(
    parameter logic [TEXT_ADDR_W-1:0] BASE_ADDRESS  = 10'h000,
    parameter bit                     BLANK_LEADING = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [BIN_W-1:0]       Value,
    input  logic                   Update,
    output logic                   Request,
    input  logic                   Grant,
    output logic [TEXT_ADDR_W-1:0] Address,
    output logic [TEXT_DATA_W-1:0] Data,
    output logic                   Write_Enable,
    output logic                   Busy
);
    state_e           state_q;
    logic             req_q, busy_q, pend_q;
    logic [BIN_W-1:0] pend_val_q;
    logic [2:0]       idx_q;

    logic             cvt_start, cvt_done;
    logic [BIN_W-1:0] cvt_bin;
    logic [BCD_W-1:0] bcd;

    assign cvt_start = (state_q == S_IDLE) && (Update || pend_q);
    assign cvt_bin   = Update ? Value : pend_val_q;

    bin_to_bcd u_bcd (
        .Clk    (Clk),
        .Reset  (Reset),
        .start_i(cvt_start),
        .bin_i  (cvt_bin),
        .done_o (cvt_done),
        .bcd_o  (bcd)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            idx_q      <= '0;
        end else begin
            // Any Update outside IDLE is parked; a later one overwrites it.
            if (Update && state_q != S_IDLE) begin
                pend_q     <= 1'b1;
                pend_val_q <= Value;
            end
            case (state_q)
                S_IDLE: begin
                    if (Update || pend_q) begin
                        state_q <= S_CONVERT;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_CONVERT: begin
                    if (cvt_done) begin
                        state_q <= S_REQUEST;
                        req_q   <= 1'b1;
                        idx_q   <= '0;
                    end
                end
                S_REQUEST: begin
                    if (Grant) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (!Grant) begin
                        state_q <= S_REQUEST;
                    end else if (idx_q == 3'(NUM_DIGITS - 1)) begin
                        state_q <= S_RELEASE;
                        req_q   <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 3'd1;
                    end
                end
                S_RELEASE: begin
                    if (!Grant) begin
                        state_q <= S_IDLE;
                        busy_q  <= pend_q || Update;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [2:0]       dig_k;
    logic [4:0]       sh;
    logic [3:0]       digit;
    logic [BCD_W-1:0] upper;
    logic             blank;

    // Character index i shows digit 4-i; a digit is blank if it and all above it are zero.
    always_comb begin
        dig_k        = 3'(NUM_DIGITS - 1) - idx_q;
        sh           = {dig_k, 2'b00};
        digit        = bcd[sh +: 4];
        upper        = bcd >> sh;
        blank        = BLANK_LEADING && (dig_k != 3'd0) && (upper == '0);
        Address      = '0;
        Data         = '0;
        Write_Enable = 1'b0;
        if (state_q == S_WRITE) begin
            Address      = BASE_ADDRESS + TEXT_ADDR_W'(idx_q);
            Data         = blank ? ASCII_SPACE : (ASCII_ZERO + {4'b0000, digit});
            Write_Enable = Grant;
        end
    end

    assign Request = req_q;
    assign Busy    = busy_q;
endmodule

// File: tb/tb_text_number_writer.sv
// Scoreboard bench: two writer instances with different base/blanking, grant model lags Request by one cycle.
module tb_text_number_writer;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Value_a, Value_b;
    logic        Update_a, Update_b;
    logic        Request_a, Request_b;
    logic        Grant_a, Grant_b;
    logic [9:0]  Address_a, Address_b;
    logic [7:0]  Data_a, Data_b;
    logic        Write_Enable_a, Write_Enable_b;
    logic        Busy_a, Busy_b;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t  qa[$];
    wr_t  qb[$];
    int   errs   = 0;
    int   checks = 0;
    logic blk_a  = 1'b0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always #5 Clk = ~Clk;

    text_number_writer #(.BASE_ADDRESS(10'h100), .BLANK_LEADING(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Value(Value_a), .Update(Update_a),
        .Request(Request_a), .Grant(Grant_a), .Address(Address_a),
        .Data(Data_a), .Write_Enable(Write_Enable_a), .Busy(Busy_a)
    );

    text_number_writer #(.BASE_ADDRESS(10'h3FE), .BLANK_LEADING(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .Value(Value_b), .Update(Update_b),
        .Request(Request_b), .Grant(Grant_b), .Address(Address_b),
        .Data(Data_b), .Write_Enable(Write_Enable_b), .Busy(Busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered arbiter: Grant in cycle n reflects Request in cycle n-1.
    always @(posedge Clk) begin
        #1;
        Grant_a = prev_a && !blk_a;
        Grant_b = prev_b;
    end

    always @(negedge Clk) begin
        wr_t e;
        prev_a = Request_a;
        prev_b = Request_b;
        if (Write_Enable_a) begin
            if (qa.size() == 0) begin
                checks++; errs++;
                $display("FAIL wr_a unexpected: addr %0h data %0h", Address_a, Data_a);
            end else begin
                e = qa.pop_front();
                chk("wr_a_addr", 32'(Address_a), 32'(e.a));
                chk("wr_a_data", 32'(Data_a), 32'(e.d));
            end
        end
        if (Write_Enable_b) begin
            if (qb.size() == 0) begin
                checks++; errs++;
                $display("FAIL wr_b unexpected: addr %0h data %0h", Address_b, Data_b);
            end else begin
                e = qb.pop_front();
                chk("wr_b_addr", 32'(Address_b), 32'(e.a));
                chk("wr_b_data", 32'(Data_b), 32'(e.d));
            end
        end
    end

    task automatic push_a(input logic [9:0] base, input logic [39:0] d, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.a = base + 10'(i);
            e.d = d[39-8*i -: 8];
            qa.push_back(e);
        end
    endtask

    task automatic push_b(input logic [9:0] base, input logic [39:0] d);
        wr_t e;
        for (int i = 0; i < 5; i++) begin
            e.a = base + 10'(i);
            e.d = d[39-8*i -: 8];
            qb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic upd_a(input logic [15:0] v);
        Value_a = v; Update_a = 1'b1;
        @(negedge Clk);
        Update_a = 1'b0;
    endtask

    task automatic upd_b(input logic [15:0] v);
        Value_b = v; Update_b = 1'b1;
        @(negedge Clk);
        Update_b = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while ((Busy_a || qa.size() != 0) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 400), 32'd1);
        chk({name, "_req_low"}, 32'(Request_a), 32'd0);
    endtask

    task automatic wait_done_b(input string name);
        int n = 0;
        while ((Busy_b || qb.size() != 0) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int n;
        Reset = 1'b0; Update_a = 1'b0; Update_b = 1'b0;
        Value_a = '0; Value_b = '0; Grant_a = 1'b0; Grant_b = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_req", 32'(Request_a), 32'd0);
        chk("rst_we", 32'(Write_Enable_a), 32'd0);
        chk("rst_busy", 32'(Busy_a), 32'd0);
        chk("rst_addr", 32'(Address_a), 32'd0);
        chk("rst_data", 32'(Data_a), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // 1234 with latency check: grant lags request by one cycle -> first write in cycle 19
        push_a(10'h100, 40'h20_31_32_33_34, 5);
        upd_a(16'd1234);
        chk("busy_c1", 32'(Busy_a), 32'd1);
        n = 1;
        while (!Write_Enable_a && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("first_wr_cycle", 32'(n), 32'd19);
        wait_done_a("v1234");

        push_a(10'h100, 40'h20_20_20_20_30, 5);
        upd_a(16'd0);
        wait_done_a("v0");
        push_a(10'h100, 40'h36_35_35_33_35, 5);
        upd_a(16'd65535);
        wait_done_a("v65535");

        // No blanking, wrapping base
        push_b(10'h3FE, 40'h30_30_30_30_37);
        upd_b(16'd7);
        wait_done_b("b7");
        push_b(10'h3FE, 40'h30_30_30_34_32);
        upd_b(16'd42);
        wait_done_b("b42");

        // Grant withheld for 10 cycles after Request
        blk_a = 1'b1;
        push_a(10'h100, 40'h20_20_35_30_30, 5);
        upd_a(16'd500);
        n = 0;
        while (!Request_a && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("req_seen", 32'(n < 100), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("hold_we", 32'(Write_Enable_a), 32'd0);
            chk("hold_req", 32'(Request_a), 32'd1);
        end
        blk_a = 1'b0;
        @(negedge Clk);
        chk("grant_back", 32'(Grant_a), 32'd1);
        chk("grant_back_we", 32'(Write_Enable_a), 32'd0);
        @(negedge Clk);
        chk("first_after_grant", 32'(Write_Enable_a), 32'd1);
        wait_done_a("hold");

        // Updates while busy: only the newest pending value survives
        push_a(10'h100, 40'h20_20_31_30_30, 5);
        push_a(10'h100, 40'h20_20_33_30_30, 5);
        upd_a(16'd100);
        repeat (5) @(negedge Clk);
        upd_a(16'd200);
        repeat (3) @(negedge Clk);
        upd_a(16'd300);
        wait_done_a("pending");

        // Grant dropped for 2 cycles after the 2nd write
        push_a(10'h100, 40'h35_34_33_32_31, 5);
        upd_a(16'd54321);
        n = 0;
        for (int t = 0; t < 100 && n < 2; t++) begin
            @(negedge Clk);
            if (Write_Enable_a) n++;
        end
        chk("two_writes", 32'(n), 32'd2);
        blk_a = 1'b1;
        repeat (2) @(negedge Clk);
        blk_a = 1'b0;
        wait_done_a("gdrop");

        // Reset during the 3rd write
        push_a(10'h100, 40'h20_39_38_37_36, 3);
        upd_a(16'd9876);
        n = 0;
        for (int t = 0; t < 100 && n < 3; t++) begin
            @(negedge Clk);
            if (Write_Enable_a) n++;
        end
        chk("three_writes", 32'(n), 32'd3);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_mid_req", 32'(Request_a), 32'd0);
        chk("rst_mid_we", 32'(Write_Enable_a), 32'd0);
        chk("rst_mid_busy", 32'(Busy_a), 32'd0);
        Reset = 1'b1;
        repeat (40) @(negedge Clk);
        chk("post_rst_req", 32'(Request_a), 32'd0);
        chk("post_rst_busy", 32'(Busy_a), 32'd0);
        chk("q_a_empty", 32'(qa.size()), 32'd0);
        chk("q_b_empty", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
